// File: rtl/alu_rr_arbiter.sv
// Round-robin front end for one shared registered ALU: grants one of NREQ requesters,
// sequences the operands through the ALU and returns the result over a valid/ready port.
module alu_rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [3*NREQ-1:0]        req_sel,
   input  logic [W*NREQ-1:0]        req_a,
   input  logic [W*NREQ-1:0]        req_b,
   output logic [NREQ-1:0]          gnt,
   output logic [W-1:0]             alu_in1,
   output logic [W-1:0]             alu_in2,
   output logic [2:0]               alu_select,
   input  logic [W:0]               alu_out,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [W:0]               rsp_data,
   output logic                     rsp_err
);

   localparam int unsigned ID_W  = $clog2(NREQ);
   localparam int unsigned SEL_W = 3;
   localparam int unsigned RES_W = W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t            state, state_nx;
   logic [ID_W-1:0]   ptr, ptr_nx;
   logic [SEL_W-1:0]  op_sel, op_sel_nx;
   logic [W-1:0]      op_a, op_a_nx;
   logic [W-1:0]      op_b, op_b_nx;
   logic [NREQ-1:0]   gnt_nx;
   logic              rsp_valid_nx;
   logic [ID_W-1:0]   rsp_id_nx;
   logic [RES_W-1:0]  rsp_data_nx;
   logic              rsp_err_nx;
   logic [ID_W-1:0]   win;
   logic              win_found;
   logic              div_zero;

   // Search starts one past the last winner and wraps, so the last winner has lowest priority.
   always_comb begin
      win       = ptr;
      win_found = 1'b0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if (!win_found && req[ptr + ID_W'(i)]) begin
            win       = ptr + ID_W'(i);
            win_found = 1'b1;
         end
      end
   end

   assign div_zero = ((op_sel == 3'b010) || (op_sel == 3'b011)) && (op_b == '0);

   assign alu_in1    = op_a;
   assign alu_in2    = op_b;
   assign alu_select = op_sel;

   always_comb begin
      state_nx     = state;
      ptr_nx       = ptr;
      op_sel_nx    = op_sel;
      op_a_nx      = op_a;
      op_b_nx      = op_b;
      gnt_nx       = '0;
      rsp_valid_nx = rsp_valid;
      rsp_id_nx    = rsp_id;
      rsp_data_nx  = rsp_data;
      rsp_err_nx   = rsp_err;

      case (state)
         IDLE: begin
            if (win_found) begin
               op_sel_nx = req_sel[SEL_W*win +: SEL_W];
               op_a_nx   = req_a[W*win +: W];
               op_b_nx   = req_b[W*win +: W];
               ptr_nx    = win;
               gnt_nx    = NREQ'(1) << win;
               state_nx  = ISSUE;
            end
         end
         ISSUE: begin
            state_nx = CAPTURE;
         end
         CAPTURE: begin
            // ptr still holds the owner of the in-flight op
            rsp_id_nx    = ptr;
            rsp_data_nx  = div_zero ? '0 : alu_out;
            rsp_err_nx   = div_zero;
            rsp_valid_nx = 1'b1;
            state_nx     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nx = 1'b0;
               state_nx     = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= ID_W'(NREQ - 1);
         op_sel    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         op_sel    <= op_sel_nx;
         op_a      <= op_a_nx;
         op_b      <= op_b_nx;
         gnt       <= gnt_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_id    <= rsp_id_nx;
         rsp_data  <= rsp_data_nx;
         rsp_err   <= rsp_err_nx;
      end
   end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter with a behavioural registered ALU attached.
module tb_alu_rr_arbiter;

   typedef struct {
      logic [1:0]  id;
      logic [16:0] data;
      logic        err;
   } rsp_t;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [11:0] req_sel;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  gnt;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   logic [2:0]  alu_select;
   logic [16:0] alu_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [16:0] rsp_data;
   logic        rsp_err;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic [3:0] gnt_q[$];
   rsp_t       rsp_q[$];

   alu_rr_arbiter #(.NREQ(4), .W(16)) dut (
      .clock(clock), .reset(reset), .req(req), .req_sel(req_sel),
      .req_a(req_a), .req_b(req_b), .gnt(gnt), .alu_in1(alu_in1),
      .alu_in2(alu_in2), .alu_select(alu_select), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Registered ALU; divide by zero returns junk that the arbiter must override.
   always @(posedge clock) begin
      case (alu_select)
         3'b000:  alu_out <= {1'b0, alu_in1} + {1'b0, alu_in2};
         3'b001:  alu_out <= {1'b0, alu_in1} - {1'b0, alu_in2};
         3'b010:  alu_out <= (alu_in2 == 16'h0) ? 17'h1DEAD : {1'b0, alu_in1 / alu_in2};
         3'b011:  alu_out <= (alu_in2 == 16'h0) ? 17'h1BEEF : {1'b0, alu_in1 % alu_in2};
         3'b100:  alu_out <= {1'b0, alu_in1 & alu_in2};
         3'b101:  alu_out <= {1'b0, alu_in1 | alu_in2};
         3'b110:  alu_out <= {1'b0, alu_in1 ^ alu_in2};
         default: alu_out <= {1'b0, ~(alu_in1 ^ alu_in2)};
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   // Grant monitor: every gnt pulse must match the next expected grant.
   always @(negedge clock) begin
      if (!reset && gnt != 4'b0) begin
         if (gnt_q.size() == 0) begin
            timeout("unexpected_gnt");
         end else begin
            chk("gnt_value", 32'(gnt), 32'(gnt_q.pop_front()));
         end
      end
   end

   // Response monitor: compares each accepted response against the scoreboard.
   always @(negedge clock) begin
      rsp_t e;
      if (!reset && rsp_valid && rsp_ready) begin
         if (rsp_q.size() == 0) begin
            timeout("unexpected_rsp");
         end else begin
            e = rsp_q.pop_front();
            chk("rsp_id",   32'(rsp_id),   32'(e.id));
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_err",  32'(rsp_err),  32'(e.err));
         end
      end
   end

   task automatic set_op(input int id, input logic [2:0] sel, input logic [15:0] a,
                         input logic [15:0] b);
      req_sel[3*id +: 3]  = sel;
      req_a[16*id +: 16]  = a;
      req_b[16*id +: 16]  = b;
   endtask

   task automatic expect_op(input int id, input logic [16:0] data, input logic err);
      rsp_t e;
      e.id   = 2'(id);
      e.data = data;
      e.err  = err;
      gnt_q.push_back(4'(1) << id);
      rsp_q.push_back(e);
   endtask

   task automatic wait_gnt(input string name);
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clock); #1;
         if (gnt != 4'b0) seen = 1;
      end
      if (!seen) timeout(name);
   endtask

   task automatic wait_rsp_done(input string name);
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clock); #1;
         if (rsp_valid) seen = 1;
      end
      if (!seen) timeout(name);
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(posedge clock); #1;
         if (!rsp_valid) seen = 1;
      end
      if (!seen) timeout(name);
   endtask

   task automatic run_op(input int id, input logic [2:0] sel, input logic [15:0] a,
                         input logic [15:0] b, input logic [16:0] data, input logic err);
      set_op(id, sel, a, b);
      expect_op(id, data, err);
      req[id] = 1'b1;
      wait_gnt("run_op_gnt");
      @(posedge clock); #1;
      req[id] = 1'b0;
      wait_rsp_done("run_op_rsp");
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_gnt"},        32'(gnt),        32'h0);
      chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'h0);
      chk({tag, "_rsp_err"},    32'(rsp_err),    32'h0);
      chk({tag, "_rsp_id"},     32'(rsp_id),     32'h0);
      chk({tag, "_rsp_data"},   32'(rsp_data),   32'h0);
      chk({tag, "_alu_in1"},    32'(alu_in1),    32'h0);
      chk({tag, "_alu_in2"},    32'(alu_in2),    32'h0);
      chk({tag, "_alu_select"}, 32'(alu_select), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int last;
      reset = 1'b1; req = 4'b0; req_sel = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      #2;
      chk_reset_values("reset");
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Single add with exact latency checks
      @(posedge clock); #1;
      set_op(0, 3'b000, 16'h0005, 16'h0003);
      expect_op(0, 17'h00008, 1'b0);
      req = 4'b0001;
      @(posedge clock); #1;
      chk("t1_gnt_latency", 32'(gnt), 32'h1);
      @(posedge clock); #1;
      chk("t1_no_early_valid", 32'(rsp_valid), 32'h0);
      req = 4'b0000;
      @(posedge clock); #1;
      chk("t1_rsp_latency", 32'(rsp_valid), 32'h1);
      @(posedge clock); #1;
      chk("t1_handshake_clears", 32'(rsp_valid), 32'h0);

      run_op(1, 3'b001, 16'h0000, 16'h0001, 17'h1FFFF, 1'b0);
      run_op(2, 3'b010, 16'h0064, 16'h0000, 17'h00000, 1'b1);
      run_op(3, 3'b011, 16'h0064, 16'h0007, 17'h00002, 1'b0);

      // All four requesting continuously: order 0,1,2,3,0 every 4 cycles
      for (int i = 0; i < 4; i++) set_op(i, 3'b000, 16'(16'h0100 * (i + 1)), 16'(i + 1));
      expect_op(0, 17'h00101, 1'b0);
      expect_op(1, 17'h00202, 1'b0);
      expect_op(2, 17'h00303, 1'b0);
      expect_op(3, 17'h00404, 1'b0);
      expect_op(0, 17'h00101, 1'b0);
      req  = 4'b1111;
      last = 0;
      for (int k = 0; k < 5; k++) begin
         wait_gnt("rr_gnt");
         if (k > 0) chk("rr_spacing", 32'(cyc - last), 32'd4);
         last = cyc;
      end
      @(posedge clock); #1;
      req = 4'b0000;
      wait_rsp_done("rr_rsp");

      // Back-pressure with further requests pending
      rsp_ready = 1'b0;
      set_op(1, 3'b110, 16'hF0F0, 16'h0FF0);
      expect_op(1, 17'h0FF00, 1'b0);
      req = 4'b0010;
      wait_gnt("stall_first_gnt");
      @(posedge clock); #1;
      set_op(1, 3'b100, 16'h1234, 16'h00FF);
      set_op(2, 3'b101, 16'h1200, 16'h0034);
      expect_op(2, 17'h01234, 1'b0);
      expect_op(1, 17'h00034, 1'b0);
      req = 4'b0110;
      begin
         bit seen = 0;
         for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clock); #1;
            if (rsp_valid) seen = 1;
         end
         if (!seen) timeout("stall_valid");
      end
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); #1;
         chk("stall_hold", {7'b0, gnt, rsp_valid, rsp_id, rsp_data, rsp_err},
             {7'b0, 4'b0000, 1'b1, 2'd1, 17'h0FF00, 1'b0});
      end
      rsp_ready = 1'b1;
      wait_gnt("stall_next_gnt");
      chk("stall_next_is_2", 32'(gnt), 32'h4);
      @(posedge clock); #1;
      req[2] = 1'b0;
      wait_gnt("stall_last_gnt");
      chk("stall_then_1", 32'(gnt), 32'h2);
      @(posedge clock); #1;
      req[1] = 1'b0;
      wait_rsp_done("stall_rsp");

      // Reset during CAPTURE aborts the op and restores ptr
      set_op(3, 3'b111, 16'hAAAA, 16'h5555);
      gnt_q.push_back(4'b1000);
      req = 4'b1000;
      wait_gnt("abort_gnt");
      @(posedge clock); #1;
      req   = 4'b0000;
      reset = 1'b1;
      #1;
      chk_reset_values("abort");
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      expect_op(0, 17'h00101, 1'b0);
      req = 4'b1111;
      wait_gnt("post_reset_gnt");
      chk("ptr_after_reset", 32'(gnt), 32'h1);
      @(posedge clock); #1;
      req = 4'b0000;
      wait_rsp_done("post_reset_rsp");

      repeat (5) @(posedge clock);
      #1;
      chk("gnt_queue_empty", 32'(gnt_q.size()), 32'd0);
      chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
